// File: rtl/conv3x3_pkg.sv
// Shared types and constants for the 3x3 convolution window front end.
package conv3x3_pkg;

    // Largest supported geometry; window coordinates are sized for it.
    localparam int unsigned MAX_IMG_W = 1024;
    localparam int unsigned MAX_IMG_H = 1024;
    localparam int unsigned WIN_COL_W = $clog2(MAX_IMG_W);
    localparam int unsigned WIN_ROW_W = $clog2(MAX_IMG_H + 1);

    // Smallest height that still produces a valid 3x3 window.
    localparam int unsigned MIN_H = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIN_ROW_W-1:0] row;
        logic [WIN_COL_W-1:0] col;
    } win_coord_t;

endpackage

// File: rtl/conv3x3_window_ctrl_raster_counter.sv
// Raster column/row position counter with column wrap and last-pixel flag.
module raster_counter #(
    parameter int unsigned COLS  = 1024,
    parameter int unsigned COL_W = $clog2(COLS),
    parameter int unsigned ROW_W = 11
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             clear,
    input  logic             advance,
    input  logic [ROW_W-1:0] last_row,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_pix_c
);

    logic wrap_c;

    always_comb begin
        wrap_c     = (col == COL_W'(COLS - 1));
        last_pix_c = wrap_c && (row == last_row);
    end

    // Column wraps at the line end and carries into the row.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (wrap_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Sequencer for the 3x3 convolution front end: pixel intake, line-buffer
// shift/flush control and a single-entry valid-window output slot.
module conv3x3_window_ctrl
    import conv3x3_pkg::*;
#(
    parameter int unsigned IMG_W = MAX_IMG_W,
    parameter int unsigned MAX_H = MAX_IMG_H,
    parameter int unsigned COL_W = $clog2(IMG_W),
    parameter int unsigned ROW_W = $clog2(MAX_H + 1)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_height,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    output logic             o_shift_en,
    output logic             o_lb_resetn,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic [ROW_W-1:0] o_win_row,
    output logic [COL_W-1:0] o_win_col,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_cfg_err
);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] height_q;
    logic [COL_W-1:0] cnt_col;
    logic [ROW_W-1:0] cnt_row;
    logic             last_pix_c;
    logic             height_ok_c;
    logic             cnt_clear_c;
    logic             pix_ready_c;
    logic             accept_c;
    logic             win_load_c;
    logic             frame_done_d;
    logic             cfg_err_d;
    logic             win_valid_q;
    win_coord_t       win_q;
    logic             lb_resetn_q;
    logic             frame_done_q;
    logic             cfg_err_q;

    assign height_ok_c = (i_height >= ROW_W'(MIN_H)) && (i_height <= ROW_W'(MAX_H));

    raster_counter #(
        .COLS  (IMG_W),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_in_pos (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .clear      (cnt_clear_c),
        .advance    (accept_c),
        .last_row   (height_q - ROW_W'(1)),
        .col        (cnt_col),
        .row        (cnt_row),
        .last_pix_c (last_pix_c)
    );

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_clear_c  = 1'b0;
        pix_ready_c  = 1'b0;
        accept_c     = 1'b0;
        win_load_c   = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (height_ok_c) begin
                        cnt_clear_c = 1'b1;
                        state_d     = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Intake only when the output slot is empty or draining this cycle.
                pix_ready_c = !win_valid_q || i_win_ready;
                accept_c    = i_pix_valid && pix_ready_c;
                win_load_c  = accept_c && (cnt_row >= ROW_W'(2)) && (cnt_col >= COL_W'(2));
                if (accept_c && last_pix_c) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!win_valid_q || i_win_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame configuration and registered status pulses.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            height_q     <= '0;
            lb_resetn_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            if (cnt_clear_c) begin
                height_q <= i_height;
            end
            lb_resetn_q  <= (state_d != IDLE);
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Output slot: window is valid the cycle after its bottom-right pixel shifts.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            win_valid_q <= 1'b0;
            win_q       <= '0;
        end else if (win_load_c) begin
            win_valid_q <= 1'b1;
            win_q.row   <= WIN_ROW_W'(cnt_row - ROW_W'(2));
            win_q.col   <= WIN_COL_W'(cnt_col - COL_W'(2));
        end else if (win_valid_q && i_win_ready) begin
            win_valid_q <= 1'b0;
        end
    end

    assign o_pix_ready  = pix_ready_c;
    assign o_shift_en   = accept_c;
    assign o_lb_resetn  = lb_resetn_q;
    assign o_win_valid  = win_valid_q;
    assign o_win_row    = ROW_W'(win_q.row);
    assign o_win_col    = COL_W'(win_q.col);
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = frame_done_q;
    assign o_cfg_err    = cfg_err_q;

endmodule

// File: doc/conv3x3_window_ctrl.md
Name: conv3x3_window_ctrl

Overview:
- Control sequencer for the 3x3 convolution front end.
- Accepts the raster pixel stream with valid/ready and tracks column and row position.
- Drives the shared shift enable for the two chained line buffers and the 3x3 window registers, and flushes the line buffers between frames.
- Flags when the window registers hold a complete in-image 3x3 window. Uses valid convolution only, so the output is (IMG_W-2) x (H-2) windows per frame.

Parameters:
- IMG_W, 1024, image width in pixels; equals the line-buffer depth; must be at least 3.
- MAX_H, 1024, largest supported runtime image height.
- COL_W, $clog2(IMG_W), column counter width (derived).
- ROW_W, $clog2(MAX_H+1), row counter and height width (derived).

Ports:
- i_clk  in  1  clock, rising edge.
- i_resetn  in  1  reset, synchronous, active-low.
- i_start  in  1  start-of-frame command; sampled in IDLE only.
- i_height  in  ROW_W  frame height; latched on an accepted start.
- i_pix_valid  in  1  upstream pixel valid.
- o_pix_ready  out  1  upstream pixel ready.
- o_shift_en  out  1  shift enable for the line buffers and window registers; equals the accept strobe.
- o_lb_resetn  out  1  registered active-low flush for the line buffers.
- o_win_valid  out  1  window output valid.
- i_win_ready  in  1  downstream window ready.
- o_win_row  out  ROW_W  top-left row of the presented window.
- o_win_col  out  COL_W  top-left column of the presented window.
- o_busy  out  1  high when the state is not IDLE.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.
- o_cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: state=IDLE; counters=0; o_win_valid=0; o_win_row=0; o_win_col=0; o_frame_done=0; o_cfg_err=0; o_lb_resetn=0. Combinational outputs are 0 while in IDLE.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - o_lb_resetn=0 (registered), so the line buffers are held empty.
  - Start with 3 <= i_height <= MAX_H: latch the height, clear the counters, go to RUN.
  - Start with any other height: pulse o_cfg_err for one cycle and stay in IDLE.
- RUN:
  - o_lb_resetn=1.
  - o_pix_ready = !o_win_valid || i_win_ready. This is a single-entry output slot, so throughput is one pixel per cycle while i_win_ready is held high.
  - accept = i_pix_valid && o_pix_ready; o_shift_en = accept (same cycle).
- On each accept at position (r,c):
  - Column counter: c wraps IMG_W-1 -> 0, and the row increments on the wrap.
  - Window output: if r >= 2 and c >= 2, the next cycle gives o_win_valid=1, o_win_row=r-2, o_win_col=c-2. The window is therefore valid one cycle after its last pixel shifts, matching the registered line-buffer read.
  - Last pixel: accepting (H-1, IMG_W-1) moves the state to FLUSH.
- Output slot:
  - Handshake on o_win_valid && i_win_ready.
  - If there is a handshake and no new window, o_win_valid clears next cycle.
  - If there is a handshake and a new window in the same cycle, the slot is reloaded and o_win_valid stays high.
  - o_win_row and o_win_col hold stable while valid and not ready.
- FLUSH:
  - o_pix_ready=0.
  - Wait until o_win_valid is low or being consumed.
  - Then pulse o_frame_done for one cycle and go to IDLE; the line-buffer flush happens there.
- i_start outside IDLE is ignored; no error is raised.
- Upstream stall (valid low) holds all counters; no bubbles are inserted into the window stream.
- Reset mid-frame: everything returns to its reset value next edge; in-flight windows are dropped and no o_frame_done is issued.
- Counter arithmetic is unsigned. Row compare is against the latched H-1 at ROW_W width. Column compare is against the constant IMG_W-1.

Decomposition:
- Shared package conv3x3_pkg:
  - State enum (IDLE/RUN/FLUSH).
  - Constant MIN_H=3.
  - Window coordinate struct {row, col}.
- Sub-module raster_counter: column/row counters with wrap and last-pixel flag, reusable for the output side.
- Everything else is flat.

Test Plan:
- IMG_W=4, H=4, 16 pixels back-to-back, i_win_ready=1 -> exactly 4 windows. They appear 1 cycle after pixel indices 10, 11, 14, 15, at (row,col) (0,0), (0,1), (1,0), (1,1). o_frame_done pulses 1 cycle after the last window handshake. o_lb_resetn is low on the following cycle.
- Same frame with i_win_ready low for 5 cycles at the first window -> o_pix_ready low for those cycles. Coordinates hold at (0,0). No window is lost or duplicated; 4 windows total.
- Start with height=2, and separately height=MAX_H+1 -> o_cfg_err pulses once for each, o_busy stays 0, and pixels are never accepted.
- i_start pulsed mid-frame -> ignored. Window count and coordinates are unchanged.
- i_resetn low at pixel 12 of an H=4 frame -> outputs take reset values next cycle and no o_frame_done. A fresh H=3 frame then yields 2 windows, (0,0) and (0,1).
- Random i_pix_valid and i_win_ready over an IMG_W=5, H=6 frame -> 12 windows, in raster order with no gaps, and o_shift_en count = 30.
